overlap_arbiter: RTL and testbench

Round-robin arbiter that shares one overlap computation unit among `N_REQ` requesters. It sits between the requesting blocks and the unit. Each accepted request is forwarded through a one-entry issue register, and its requester ID is recorded in an in-order tag FIFO. Each unit response is routed back to the requester that issued it, with backpressure honoured end to end.

---
 rtl/overlap_pkg.sv | 22 ++
 rtl/overlap_tag_fifo.sv | 40 ++++
 rtl/overlap_arbiter.sv | 80 ++++++++
 tb/tb_overlap_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/overlap_pkg.sv
// overlap_pkg: shared box/overlap payload types, widths and issue FSM states
package overlap_pkg;
  localparam int COORD_W = 8;
  localparam int AREA_W = 16;
  typedef struct packed {
    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;
  } box_t;
  typedef struct packed {
    box_t a;
    box_t b;
  } overlap_input;
  typedef struct packed {
    logic ovl;
    logic [AREA_W-1:0] area;
  } overlap_output;
  localparam int REQ_W = $bits(overlap_input);
  localparam int RSP_W = $bits(overlap_output);
  typedef enum logic {IDLE, ISSUE} issue_state_e;
endpackage

// File: rtl/overlap_tag_fifo.sv
// overlap_tag_fifo: in-order tag FIFO; push_i/data_i in, pop_i/data_o out, full_o/empty_o/count_o status
module overlap_tag_fifo #(
  parameter int DEPTH = 3,
  parameter int W = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [W-1:0]     data_i,
  input  logic             pop_i,
  output logic [W-1:0]     data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);
  logic [W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic do_push, do_pop;
  assign do_push = push_i && !full_o;
  assign do_pop = pop_i && !empty_o;
  assign full_o = cnt_q == CNT_W'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign data_o = mem_q[rd_q];
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= data_i;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= (wr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
      if (do_pop) rd_q <= (rd_q == PTR_W'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
      cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
endmodule

// File: rtl/overlap_arbiter.sv
// overlap_arbiter: round-robin share of one overlap unit; req_* from requesters, ovl_in_*/ovl_out_* to the unit, rsp_* routed back, outstanding/err status
module overlap_arbiter #(
  parameter int N_REQ = 4,
  parameter int REQ_W = overlap_pkg::REQ_W,
  parameter int RSP_W = overlap_pkg::RSP_W,
  parameter int MAX_OUT = 3,
  localparam int TAG_W = $clog2(N_REQ),
  localparam int CNT_W = $clog2(MAX_OUT + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*REQ_W-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic               ovl_in_valid,
  output logic [REQ_W-1:0]   ovl_in_data,
  input  logic               ovl_in_ready,
  input  logic               ovl_out_valid,
  input  logic [RSP_W-1:0]   ovl_out_data,
  output logic               ovl_out_ready,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [RSP_W-1:0]   rsp_data,
  input  logic [N_REQ-1:0]   rsp_ready,
  output logic [CNT_W-1:0]   outstanding,
  output logic               err
);
  import overlap_pkg::*;
  issue_state_e state_q;
  logic [REQ_W-1:0] data_q;
  logic [TAG_W-1:0] rr_q, gnt_idx, idx, head;
  logic found, grant, empty, pop, err_q;
  always_comb begin
    found = 1'b0;
    gnt_idx = rr_q;
    idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = TAG_W'((int'(rr_q) + k) % N_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gnt_idx = idx;
      end
    end
  end
  // credit check uses the registered count, so a same-cycle pop never frees a slot early
  assign grant = rst_n && found && outstanding < CNT_W'(MAX_OUT) && (state_q == IDLE || ovl_in_ready);
  assign req_ready = grant ? N_REQ'(1) << gnt_idx : '0;
  assign ovl_in_valid = state_q == ISSUE;
  assign ovl_in_data = data_q;
  assign err = err_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      data_q <= '0;
      rr_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= err_q || (empty && ovl_out_valid);
      if (grant) begin
        state_q <= ISSUE;
        data_q <= req_data[int'(gnt_idx)*REQ_W +: REQ_W];
        rr_q <= (gnt_idx == TAG_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end else if (ovl_in_ready) state_q <= IDLE;
    end
  overlap_tag_fifo #(.DEPTH(MAX_OUT), .W(TAG_W)) u_tags (
    .clk(clk),
    .rst_n(rst_n),
    .push_i(grant),
    .data_i(gnt_idx),
    .pop_i(pop),
    .data_o(head),
    .full_o(),
    .empty_o(empty),
    .count_o(outstanding)
  );
  // a response with no owner is accepted and dropped so the unit cannot wedge
  assign pop = ovl_out_valid && rsp_ready[head] && !empty;
  assign ovl_out_ready = empty ? ovl_out_valid && rst_n : rsp_ready[head];
  assign rsp_valid = (ovl_out_valid && !empty) ? N_REQ'(1) << head : '0;
  assign rsp_data = ovl_out_data;
endmodule

// File: tb/tb_overlap_arbiter.sv
// tb_overlap_arbiter: scoreboard bench with requester/unit models and directed vectors
module tb_overlap_arbiter;
  import overlap_pkg::*;
  localparam int N = 4;
  localparam logic [63:0] A = {8'd0, 8'd0, 8'd10, 8'd10, 8'd5, 8'd5, 8'd15, 8'd15};
  localparam logic [63:0] B = {8'd0, 8'd0, 8'd4, 8'd4, 8'd2, 8'd1, 8'd6, 8'd3};
  localparam logic [63:0] C = {8'd0, 8'd0, 8'd5, 8'd5, 8'd5, 8'd0, 8'd9, 8'd5};
  localparam logic [63:0] D = {8'd10, 8'd20, 8'd30, 8'd40, 8'd0, 8'd0, 8'd100, 8'd100};
  localparam logic [63:0] E = {8'd0, 8'd0, 8'd255, 8'd255, 8'd0, 8'd0, 8'd255, 8'd255};
  localparam logic [16:0] RA = 17'h10019;
  localparam logic [16:0] RB = 17'h10004;
  localparam logic [16:0] RC = 17'h00000;
  localparam logic [16:0] RD = 17'h10190;
  localparam logic [16:0] RE = 17'h1FE01;
  typedef struct packed {
    logic [1:0] id;
    logic [16:0] d;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*64-1:0] req_data;
  logic ovl_in_valid, ovl_in_ready, ovl_out_valid, ovl_out_ready, err;
  logic [63:0] ovl_in_data;
  logic [16:0] ovl_out_data, rsp_data;
  logic [1:0] outstanding;
  logic [63:0] pd [N][4];
  int pc [N] = '{0, 0, 0, 0};
  logic [16:0] uq [$];
  int u_cnt = 0;
  logic [16:0] u_head = '0;
  logic unit_en = 1'b0, inject = 1'b0;
  int glog [$];
  exp_t exp_q [$];
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  assign ovl_out_valid = (unit_en && u_cnt > 0) || inject;
  assign ovl_out_data = inject ? 17'h1ABCD : u_head;
  overlap_arbiter #(.N_REQ(N), .MAX_OUT(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .ovl_in_valid(ovl_in_valid), .ovl_in_data(ovl_in_data), .ovl_in_ready(ovl_in_ready),
    .ovl_out_valid(ovl_out_valid), .ovl_out_data(ovl_out_data), .ovl_out_ready(ovl_out_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .outstanding(outstanding), .err(err)
  );
  function automatic logic [16:0] unit_calc(input logic [63:0] d);
    overlap_input p;
    int ix, iy;
    p = d;
    ix = ((p.a.x1 < p.b.x1) ? int'(p.a.x1) : int'(p.b.x1)) - ((p.a.x0 > p.b.x0) ? int'(p.a.x0) : int'(p.b.x0));
    iy = ((p.a.y1 < p.b.y1) ? int'(p.a.y1) : int'(p.b.y1)) - ((p.a.y0 > p.b.y0) ? int'(p.a.y0) : int'(p.b.y0));
    return (ix > 0 && iy > 0) ? {1'b1, 16'(ix * iy)} : 17'd0;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic push_req(input int i, input logic [63:0] d);
    pd[i][pc[i]] = d;
    pc[i]++;
  endtask
  task automatic expect_rsp(input int i, input logic [16:0] d);
    exp_t e;
    e.id = 2'(i);
    e.d = d;
    exp_q.push_back(e);
  endtask
  task automatic cyc();
    @(posedge clk);
    #3;
  endtask
  task automatic wait_grant(input string name, input logic [3:0] exp);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ready == '0 && n < 10);
    chk(name, req_ready, exp);
  endtask
  task automatic drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask
  task automatic chk_order(input string name, input int n, input logic [19:0] ord);
    chk({name, "_count"}, glog.size(), n);
    for (int k = 0; k < n; k++)
      chk(name, k < glog.size() ? glog[k] : 99, ord[4*(n-1-k) +: 4]);
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_ovl_in_valid"}, ovl_in_valid, 0);
    chk({tag, "_ovl_in_data"}, ovl_in_data, 0);
    chk({tag, "_ovl_out_ready"}, ovl_out_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_outstanding"}, outstanding, 0);
    chk({tag, "_err"}, err, 0);
  endtask
  initial begin
    logic [N-1:0] g;
    logic hs_in, hs_out;
    logic [63:0] din;
    req_valid = '0;
    req_data = '0;
    forever begin
      @(negedge clk);
      g = req_valid & req_ready;
      hs_in = ovl_in_valid && ovl_in_ready;
      din = ovl_in_data;
      hs_out = ovl_out_valid && ovl_out_ready && !inject;
      @(posedge clk);
      #1;
      if (!rst_n) uq.delete();
      else begin
        if (hs_out && uq.size() > 0) void'(uq.pop_front());
        if (hs_in) uq.push_back(unit_calc(din));
      end
      for (int i = 0; i < N; i++)
        if (g[i]) begin
          glog.push_back(i);
          for (int k = 0; k < 3; k++) pd[i][k] = pd[i][k+1];
          pc[i]--;
        end
      for (int i = 0; i < N; i++) begin
        req_valid[i] = pc[i] > 0;
        req_data[i*64 +: 64] = pd[i][0];
      end
      u_cnt = uq.size();
      u_head = uq.size() > 0 ? uq[0] : '0;
    end
  end
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (rsp_valid & rsp_ready) != '0) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_rsp: got rsp_valid %b data %0h, none expected", rsp_valid, rsp_data);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_route", rsp_valid, 4'b1 << e.id);
          chk("rsp_data", rsp_data, e.d);
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1);
  end
  initial begin
    ovl_in_ready = 1'b0;
    rsp_ready = '1;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    cyc();
    rst_n = 1'b1;
    ovl_in_ready = 1'b1;
    unit_en = 1'b1;
    push_req(0, A);
    expect_rsp(0, RA);
    wait_grant("t1_grant", 4'b0001);
    chk("t1_in_valid_T", ovl_in_valid, 0);
    @(negedge clk);
    chk("t1_in_valid_T1", ovl_in_valid, 1);
    chk("t1_in_data", ovl_in_data, A);
    drain("t1_drain", 20);
    cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    glog.delete();
    push_req(0, A);
    push_req(0, E);
    push_req(1, B);
    push_req(2, C);
    push_req(3, D);
    expect_rsp(0, RA);
    expect_rsp(1, RB);
    expect_rsp(2, RC);
    expect_rsp(3, RD);
    expect_rsp(0, RE);
    drain("t2_drain", 40);
    chk_order("t2_order", 5, 20'h01230);
    cyc();
    ovl_in_ready = 1'b0;
    unit_en = 1'b0;
    glog.delete();
    push_req(0, A);
    push_req(1, B);
    push_req(2, C);
    push_req(3, D);
    expect_rsp(1, RB);
    expect_rsp(2, RC);
    expect_rsp(3, RD);
    expect_rsp(0, RA);
    wait_grant("t3_grant", 4'b0010);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t3_hold_valid", ovl_in_valid, 1);
      chk("t3_hold_data", ovl_in_data, B);
      chk("t3_stall_no_grant", req_ready, 0);
    end
    cyc();
    ovl_in_ready = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t3_full_no_grant", req_ready, 0);
    end
    chk("t3_full_count", outstanding, 3);
    chk("t3_grants", glog.size(), 3);
    cyc();
    unit_en = 1'b1;
    @(negedge clk);
    chk("t3_pop_no_grant", req_ready, 0);
    chk("t3_pop_count", outstanding, 3);
    @(negedge clk);
    chk("t3_regrant", req_ready, 4'b0001);
    drain("t3_drain", 30);
    chk_order("t3_order", 4, 20'h01230);
    cyc();
    unit_en = 1'b0;
    push_req(2, C);
    expect_rsp(2, RC);
    wait_grant("t4_grant2", 4'b0100);
    cyc();
    push_req(0, A);
    expect_rsp(0, RA);
    wait_grant("t4_grant0", 4'b0001);
    repeat (2) @(negedge clk);
    cyc();
    rsp_ready = 4'b1011;
    unit_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_stall_rsp_valid", rsp_valid, 4'b0100);
      chk("t4_stall_out_ready", ovl_out_ready, 0);
    end
    cyc();
    rsp_ready = '1;
    drain("t4_drain", 10);
    cyc();
    inject = 1'b1;
    @(negedge clk);
    chk("t5_drop_ready", ovl_out_ready, 1);
    chk("t5_drop_rsp_valid", rsp_valid, 0);
    chk("t5_err_before", err, 0);
    cyc();
    inject = 1'b0;
    @(negedge clk);
    chk("t5_err_set", err, 1);
    repeat (3) @(negedge clk);
    chk("t5_err_sticky", err, 1);
    chk("t5_count", outstanding, 0);
    cyc();
    unit_en = 1'b0;
    push_req(1, B);
    push_req(3, D);
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!(outstanding == 2'd2 && !ovl_in_valid) && n < 20);
    end
    chk("t6_two_out", outstanding, 2);
    cyc();
    rst_n = 1'b0;
    push_req(0, A);
    push_req(2, C);
    #1;
    chk_reset_outputs("t6_async");
    repeat (2) @(negedge clk);
    chk("t6_rst_no_grant", req_ready, 0);
    cyc();
    rst_n = 1'b1;
    unit_en = 1'b1;
    glog.delete();
    expect_rsp(0, RA);
    expect_rsp(2, RC);
    @(negedge clk);
    chk("t6_post_grant", req_ready, 4'b0001);
    drain("t6_drain", 20);
    chk_order("t6_order", 2, 20'h00002);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
